// File: rtl/fht_loader_pkg.sv
// Shared types for the FHT input loader: FSM state encoding and bank write-enable helper.
package fht_loader_pkg;

  typedef enum logic [2:0] {
    LD_LOAD    = 3'd0,
    LD_LAST_WR = 3'd1,
    LD_START   = 3'd2,
    LD_BUSY    = 3'd3,
    LD_DONE    = 3'd4
  } loader_state_e;

  // One-hot write enable for the RAM(A) bank selected by the low two index bits.
  function automatic logic [3:0] bank_we(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/fht_addr_map.sv
// Maps a sample index n onto {bank, addr} in RAM(A), optionally bit-reversing n first.
module fht_addr_map #(
  parameter int A_BIT   = 8,
  parameter int BIT_REV = 1
) (
  input  logic [A_BIT+1:0] idx,
  output logic [1:0]       bank,
  output logic [A_BIT-1:0] addr
);

  localparam int N_LOG2 = A_BIT + 2;

  logic [N_LOG2-1:0] m;

  generate
    if (BIT_REV != 0) begin : g_rev
      for (genvar gi = 0; gi < N_LOG2; gi++) begin : g_bit
        assign m[gi] = idx[N_LOG2-1-gi];
      end
    end else begin : g_lin
      assign m = idx;
    end
  endgenerate

  assign bank = m[1:0];
  assign addr = m[N_LOG2-1:2];

endmodule

// File: rtl/fht_loader.sv
// Input stage for fht_top: streams one frame of samples into RAM(A), starts the transform
// and holds the stream off until fht_top signals completion with a rising oRDY.
module fht_loader
  import fht_loader_pkg::*;
#(
  parameter int D_BIT   = 17,
  parameter int A_BIT   = 8,
  parameter int BIT_REV = 1,
  parameter int CNT_BIT = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iCLR,
  input  logic               iVALID,
  input  logic [D_BIT-2:0]   iSAMPLE,
  output logic               oREADY,
  output logic [D_BIT-2:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic               oWE_0,
  output logic               oWE_1,
  output logic               oWE_2,
  output logic               oWE_3,
  output logic               oSTART,
  input  logic               iRDY,
  output logic               oBUSY,
  output logic               oFRAME_DONE,
  output logic [CNT_BIT-1:0] oDROP_CNT
);

  localparam int N_LOG2 = A_BIT + 2;

  loader_state_e      state_q, state_d;
  logic [N_LOG2-1:0]  index_q, index_d;
  logic [D_BIT-2:0]   data_q, data_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [3:0]         we_q, we_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               rdy_q, rdy_d;
  logic [CNT_BIT-1:0] drop_cnt_q, drop_cnt_d;

  logic               ready;
  logic               accept;
  logic [1:0]         map_bank;
  logic [A_BIT-1:0]   map_addr;

  fht_addr_map #(
    .A_BIT   (A_BIT),
    .BIT_REV (BIT_REV)
  ) u_addr_map (
    .idx  (index_q),
    .bank (map_bank),
    .addr (map_addr)
  );

  assign ready  = (state_q == LD_LOAD);
  assign accept = iVALID & ready & ~iCLR;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    data_d       = data_q;
    addr_d       = addr_q;
    we_d         = 4'b0000;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    rdy_d        = rdy_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      LD_LOAD: begin
        if (accept) begin
          // The index parks at N-1 until DONE so it can never wrap inside LOAD.
          if (index_q == '1) begin
            state_d = LD_LAST_WR;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      LD_LAST_WR: begin
        state_d = LD_START;
        start_d = 1'b1;
      end
      LD_START: begin
        rdy_d   = iRDY;
        state_d = LD_BUSY;
      end
      LD_BUSY: begin
        rdy_d = iRDY;
        if (iRDY && !rdy_q) begin
          state_d      = LD_DONE;
          frame_done_d = 1'b1;
        end
      end
      LD_DONE: begin
        index_d = '0;
        state_d = LD_LOAD;
      end
      default: begin
        state_d = LD_LOAD;
        index_d = '0;
      end
    endcase

    if (accept) begin
      data_d = iSAMPLE;
      addr_d = map_addr;
      we_d   = bank_we(map_bank);
    end

    busy_d = (state_d == LD_START) || (state_d == LD_BUSY);

    if (iVALID && !ready && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    if (iCLR) begin
      state_d      = LD_LOAD;
      index_d      = '0;
      we_d         = 4'b0000;
      start_d      = 1'b0;
      frame_done_d = 1'b0;
      busy_d       = 1'b0;
      rdy_d        = 1'b0;
      drop_cnt_d   = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q      <= LD_LOAD;
      index_q      <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      we_q         <= 4'b0000;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rdy_q        <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rdy_q        <= rdy_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign oREADY      = ready;
  assign oDATA       = data_q;
  assign oADDR_WR    = addr_q;
  assign oWE_0       = we_q[0];
  assign oWE_1       = we_q[1];
  assign oWE_2       = we_q[2];
  assign oWE_3       = we_q[3];
  assign oSTART      = start_q;
  assign oBUSY       = busy_q;
  assign oFRAME_DONE = frame_done_q;
  assign oDROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_fht_loader.sv
// Scoreboard bench: two loaders (linear/16-bit counter and bit-reversed/3-bit counter) share stimulus.
`timescale 1ns/1ps
module tb_fht_loader;

  localparam int D_BIT = 17;
  localparam int SW    = D_BIT - 1;
  localparam int A_BIT = 8;
  localparam int LOG2N = A_BIT + 2;
  localparam int N     = 1 << LOG2N;
  localparam int CNT0  = 16;
  localparam int CNT1  = 3;
  localparam int MAX0  = (1 << CNT0) - 1;
  localparam int MAX1  = (1 << CNT1) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clr, valid, rdy;
  logic [SW-1:0] sample;

  logic            ready0, start0, busy0, done0, we0_0, we0_1, we0_2, we0_3;
  logic [SW-1:0]   data0;
  logic [A_BIT-1:0] addr0;
  logic [CNT0-1:0] drop0;
  logic            ready1, start1, busy1, done1, we1_0, we1_1, we1_2, we1_3;
  logic [SW-1:0]   data1;
  logic [A_BIT-1:0] addr1;
  logic [CNT1-1:0] drop1;

  fht_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BIT_REV(0), .CNT_BIT(CNT0)) dut0 (
    .iCLK(clk), .iRESET(rst_n), .iCLR(clr), .iVALID(valid), .iSAMPLE(sample),
    .oREADY(ready0), .oDATA(data0), .oADDR_WR(addr0),
    .oWE_0(we0_0), .oWE_1(we0_1), .oWE_2(we0_2), .oWE_3(we0_3),
    .oSTART(start0), .iRDY(rdy), .oBUSY(busy0), .oFRAME_DONE(done0), .oDROP_CNT(drop0)
  );

  fht_loader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .BIT_REV(1), .CNT_BIT(CNT1)) dut1 (
    .iCLK(clk), .iRESET(rst_n), .iCLR(clr), .iVALID(valid), .iSAMPLE(sample),
    .oREADY(ready1), .oDATA(data1), .oADDR_WR(addr1),
    .oWE_0(we1_0), .oWE_1(we1_1), .oWE_2(we1_2), .oWE_3(we1_3),
    .oSTART(start1), .iRDY(rdy), .oBUSY(busy1), .oFRAME_DONE(done1), .oDROP_CNT(drop1)
  );

  typedef struct {
    int cyc;
    int bank;
    int addr;
    int data;
  } wexp_t;

  wexp_t wq0[$];
  wexp_t wq1[$];
  int    sq0[$], sq1[$], dq0[$], dq1[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: frame progress expressed as sample counts and event timestamps.
  int loaded     = 0;
  bit waiting    = 1'b0;
  int start_cyc  = 0;
  int resume_cyc = 0;
  bit prev_rdy   = 1'b0;
  int drop_m0    = 0;
  int drop_m1    = 0;

  bit exp_ready = 1'b1;
  bit exp_busy  = 1'b0;
  int exp_drop0 = 0;
  int exp_drop1 = 0;

  function automatic int map_of(input int n, input bit rev);
    int r;
    if (!rev) return n;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      if (((n >> i) & 1) != 0) r = r | (1 << (LOG2N - 1 - i));
    end
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic mon_dut(input int id, input int we, input int addr, input int data,
                         input bit st, input bit fd, input bit rdyo, input bit bsy,
                         input int drp);
    wexp_t e;
    bit    have;
    int    ec;
    have = (id == 0) ? (wq0.size() > 0) : (wq1.size() > 0);
    if (have) e = (id == 0) ? wq0[0] : wq1[0];
    if (we != 0) begin
      if (!have) begin
        check($sformatf("dut%0d_we_unexpected", id), we, 0);
      end else begin
        if (id == 0) void'(wq0.pop_front()); else void'(wq1.pop_front());
        check($sformatf("dut%0d_we_cycle", id), cyc, e.cyc);
        check($sformatf("dut%0d_we_bank", id), we, 1 << e.bank);
        check($sformatf("dut%0d_addr", id), addr, e.addr);
        check($sformatf("dut%0d_data", id), data, e.data);
      end
    end else if (have && e.cyc <= cyc) begin
      if (id == 0) void'(wq0.pop_front()); else void'(wq1.pop_front());
      check($sformatf("dut%0d_we_missing", id), we, 1 << e.bank);
    end

    have = (id == 0) ? (sq0.size() > 0) : (sq1.size() > 0);
    if (have) ec = (id == 0) ? sq0[0] : sq1[0];
    if (st) begin
      if (!have) begin
        check($sformatf("dut%0d_start_unexpected", id), int'(st), 0);
      end else begin
        if (id == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
        check($sformatf("dut%0d_start_cycle", id), cyc, ec);
        $display("cycle %0d dut%0d oSTART", cyc, id);
      end
    end else if (have && ec <= cyc) begin
      if (id == 0) void'(sq0.pop_front()); else void'(sq1.pop_front());
      check($sformatf("dut%0d_start_missing", id), int'(st), 1);
    end

    have = (id == 0) ? (dq0.size() > 0) : (dq1.size() > 0);
    if (have) ec = (id == 0) ? dq0[0] : dq1[0];
    if (fd) begin
      if (!have) begin
        check($sformatf("dut%0d_done_unexpected", id), int'(fd), 0);
      end else begin
        if (id == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
        check($sformatf("dut%0d_done_cycle", id), cyc, ec);
        $display("cycle %0d dut%0d oFRAME_DONE", cyc, id);
      end
    end else if (have && ec <= cyc) begin
      if (id == 0) void'(dq0.pop_front()); else void'(dq1.pop_front());
      check($sformatf("dut%0d_done_missing", id), int'(fd), 1);
    end

    check($sformatf("dut%0d_ready", id), int'(rdyo), int'(exp_ready));
    check($sformatf("dut%0d_busy", id), int'(bsy), int'(exp_busy));
    check($sformatf("dut%0d_drop_cnt", id), drp, (id == 0) ? exp_drop0 : exp_drop1);
  endtask

  always @(negedge clk) begin
    mon_dut(0, int'({we0_3, we0_2, we0_1, we0_0}), int'(addr0), int'(data0),
            start0, done0, ready0, busy0, int'(drop0));
    mon_dut(1, int'({we1_3, we1_2, we1_1, we1_0}), int'(addr1), int'(data1),
            start1, done1, ready1, busy1, int'(drop1));
  end

  task automatic model_cycle(input bit v, input bit r, input bit c, input int s);
    wexp_t e;
    int    m;
    exp_ready = !waiting && (cyc >= resume_cyc);
    exp_busy  = waiting && (cyc >= start_cyc);
    exp_drop0 = drop_m0;
    exp_drop1 = drop_m1;
    if (c) begin
      loaded     = 0;
      waiting    = 1'b0;
      resume_cyc = cyc + 1;
      drop_m0    = 0;
      drop_m1    = 0;
    end else begin
      if (v && !exp_ready) begin
        if (drop_m0 < MAX0) drop_m0++;
        if (drop_m1 < MAX1) drop_m1++;
      end
      if (v && exp_ready) begin
        m = map_of(loaded, 1'b0);
        e.cyc = cyc + 1; e.bank = m % 4; e.addr = m / 4; e.data = s;
        wq0.push_back(e);
        m = map_of(loaded, 1'b1);
        e.bank = m % 4; e.addr = m / 4;
        wq1.push_back(e);
        loaded++;
        if (loaded == N) begin
          waiting   = 1'b1;
          start_cyc = cyc + 2;
          sq0.push_back(cyc + 2);
          sq1.push_back(cyc + 2);
        end
      end else if (waiting && (cyc >= start_cyc + 1) && r && !prev_rdy) begin
        waiting    = 1'b0;
        loaded     = 0;
        resume_cyc = cyc + 2;
        dq0.push_back(cyc + 1);
        dq1.push_back(cyc + 1);
      end
    end
    prev_rdy = r;
  endtask

  task automatic step(input bit v, input bit r, input bit c, input logic [SW-1:0] s);
    @(posedge clk);
    #1;
    cyc++;
    rst_n  = 1'b1;
    valid  = v;
    rdy    = r;
    clr    = c;
    sample = s;
    model_cycle(v, r, c, int'(s));
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1'b0;
      valid = 1'b0;
      clr   = 1'b0;
      loaded = 0; waiting = 1'b0; resume_cyc = cyc; drop_m0 = 0; drop_m1 = 0;
      prev_rdy = rdy;
      wq0.delete(); wq1.delete(); sq0.delete(); sq1.delete(); dq0.delete(); dq1.delete();
      exp_ready = 1'b1; exp_busy = 1'b0; exp_drop0 = 0; exp_drop1 = 0;
      @(negedge clk);
      check("reset_data0", int'(data0), 0);
      check("reset_addr0", int'(addr0), 0);
      check("reset_data1", int'(data1), 0);
      check("reset_addr1", int'(addr1), 0);
    end
  endtask

  task automatic run_load(input int target, input int pct);
    int guard;
    bit v;
    guard = 0;
    while (loaded < target && !waiting && guard < 20000) begin
      v = ($urandom_range(99) < pct);
      step(v, rdy, 1'b0, SW'($urandom));
      guard++;
    end
  endtask

  task automatic run_busy();
    int guard;
    guard = 0;
    while (waiting && guard < 500) begin
      step($urandom_range(1), $urandom_range(1), 1'b0, SW'($urandom));
      guard++;
    end
    while (waiting && guard < 510) begin
      step(1'b0, guard[0], 1'b0, SW'($urandom));
      guard++;
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; rdy = 1'b0; sample = '0;
    do_reset(3);

    // Back-to-back frame of samples 0..N-1 with iRDY held high through oSTART.
    for (int n = 0; n < N; n++) step(1'b1, 1'b1, 1'b0, SW'(n));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, SW'($urandom));
    repeat (5) step(1'b1, 1'b0, 1'b0, SW'($urandom));
    step(1'b1, 1'b1, 1'b0, SW'($urandom));
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check("drop_after_busy_dut0", int'(drop0), 7);
    check("drop_after_busy_dut1", int'(drop1), 7);
    step(1'b0, 1'b1, 1'b0, '0);

    // Randomised frame; dut1's 3-bit drop counter must stay saturated.
    run_load(N, 60);
    run_busy();

    // Clear after 300 samples; the offered sample is dropped and not counted.
    run_load(300, 70);
    step(1'b1, 1'b0, 1'b1, SW'($urandom));
    run_load(N, 80);
    run_busy();

    // Async reset while BUSY; a later iRDY rise must not complete anything.
    run_load(N, 90);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    do_reset(1);
    step(1'b0, 1'b0, 1'b0, '0);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    run_load(8, 100);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("pending_events", wq0.size() + wq1.size() + sq0.size() + sq1.size()
                            + dq0.size() + dq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
